// File: rtl/svc_rv_perf_mon.sv
// Performance monitor: cycle, retired-instruction and event counters over a start/stop
// window, then a sequential restoring divide for CPI. Saturating counters: SVC_RV_PERF_MON_SAT_EN.
module svc_rv_perf_mon #(
    parameter int CNT_W   = 32,
    parameter int NUM_EVT = 2,
    parameter int FRAC_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       clear,
    input  logic                       retire,
    input  logic [NUM_EVT-1:0]         evt,
    output logic                       running,
    output logic [CNT_W-1:0]           cycles,
    output logic [CNT_W-1:0]           instrs,
    output logic [NUM_EVT*CNT_W-1:0]   evt_cnt,
    output logic [NUM_EVT+1:0]         ovf,
    output logic [CNT_W+FRAC_W-1:0]    cpi,
    output logic                       cpi_div0,
    output logic                       cpi_valid,
    input  logic                       cpi_ready
);

    localparam int Q     = CNT_W + FRAC_W;
    localparam int BIT_W = $clog2(Q);
    localparam int NCNT  = NUM_EVT + 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DIV, S_DONE} state_t;

    state_t             r_state, w_next;
    // Counter slot 0 = cycles, 1 = retired instructions, 2+i = event i.
    logic [CNT_W-1:0]   r_cnt [NCNT];
    logic [NCNT-1:0]    r_ovf;
    logic [Q-1:0]       r_cpi;
    logic               r_div0;
    logic [Q-2:0]       r_quo;
    logic [CNT_W-1:0]   r_rem;
    logic [BIT_W-1:0]   r_bit;

    logic [CNT_W:0]     w_bump [NCNT];
    logic [NCNT-1:0]    w_inc;
    logic [Q-1:0]       w_dividend;
    logic               w_dvd_bit;
    logic [CNT_W:0]     w_rem_sh;
    logic               w_ge;
    logic [CNT_W-1:0]   w_rem_nx;
    logic [Q-1:0]       w_quo_nx;
    logic               w_div0;
    logic               w_last;

    assign w_inc = {evt, retire, 1'b1};

    // {overflow, next value} for every counter assuming it increments this cycle.
    always_comb begin
        for (int k = 0; k < NCNT; k++) begin
            if (&r_cnt[k]) begin
`ifdef SVC_RV_PERF_MON_SAT_EN
                w_bump[k] = {1'b1, r_cnt[k]};
`else
                w_bump[k] = {1'b1, {CNT_W{1'b0}}};
`endif
            end else begin
                w_bump[k] = {1'b0, r_cnt[k] + CNT_W'(1)};
            end
        end
    end

    // One restoring-divide step: shift the next dividend bit into the remainder.
    assign w_dividend = {r_cnt[0], {FRAC_W{1'b0}}};
    assign w_dvd_bit  = w_dividend[BIT_W'(Q - 1) - r_bit];
    assign w_rem_sh   = {r_rem, w_dvd_bit};
    assign w_ge       = (w_rem_sh >= {1'b0, r_cnt[1]});
    assign w_rem_nx   = w_ge ? CNT_W'(w_rem_sh - {1'b0, r_cnt[1]}) : w_rem_sh[CNT_W-1:0];
    assign w_quo_nx   = {r_quo, w_ge};
    assign w_div0     = (r_cnt[1] == '0);
    assign w_last     = (r_bit == BIT_W'(Q - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: assign the default first so every path drives w_next and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_RUN;
            S_RUN:  if (stop) w_next = S_DIV;
            S_DIV:  if (w_div0 || w_last) w_next = S_DONE;
            S_DONE: if (cpi_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (clear) w_next = S_IDLE;
    end

    // NOTE: the counter array is ordinary flops, not RAM, so it is reset element by element.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int k = 0; k < NCNT; k++) r_cnt[k] <= '0;
            r_ovf  <= '0;
            r_cpi  <= '0;
            r_div0 <= 1'b0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_bit  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NCNT; k++) r_cnt[k] <= '0;
                        r_ovf <= '0;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < NCNT; k++) begin
                        if (w_inc[k]) begin
                            r_cnt[k] <= w_bump[k][CNT_W-1:0];
                            r_ovf[k] <= r_ovf[k] | w_bump[k][CNT_W];
                        end
                    end
                    if (stop) begin
                        r_quo <= '0;
                        r_rem <= '0;
                        r_bit <= '0;
                    end
                end
                S_DIV: begin
                    if (w_div0) begin
                        r_cpi  <= '1;
                        r_div0 <= 1'b1;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx[Q-2:0];
                        r_bit <= r_bit + BIT_W'(1);
                        if (w_last) begin
                            r_cpi  <= w_quo_nx;
                            r_div0 <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign running   = (r_state == S_RUN);
    assign cpi_valid = (r_state == S_DONE);
    assign cycles    = r_cnt[0];
    assign instrs    = r_cnt[1];
    assign ovf       = r_ovf;
    assign cpi       = r_cpi;
    assign cpi_div0  = r_div0;

    for (genvar g = 0; g < NUM_EVT; g++) begin : g_evt
        assign evt_cnt[g*CNT_W +: CNT_W] = r_cnt[g+2];
    end

endmodule

// File: tb/tb_svc_rv_perf_mon.sv
// Self-checking bench for svc_rv_perf_mon: default instance plus a CNT_W=8 instance for overflow.
module tb_svc_rv_perf_mon;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance (CNT_W=32, NUM_EVT=2, FRAC_W=8)
    logic        d_start = 0, d_stop = 0, d_clear = 0, d_retire = 0, d_ready = 0;
    logic [1:0]  d_evt = '0;
    logic        d_running, d_cpi_div0, d_cpi_valid;
    logic [31:0] d_cycles, d_instrs;
    logic [63:0] d_evt_cnt;
    logic [3:0]  d_ovf;
    logic [39:0] d_cpi;

    // Narrow instance (CNT_W=8)
    logic        s_start = 0, s_stop = 0, s_clear = 0, s_retire = 0, s_ready = 0;
    logic [1:0]  s_evt = '0;
    logic        s_running, s_cpi_div0, s_cpi_valid;
    logic [7:0]  s_cycles, s_instrs;
    logic [15:0] s_evt_cnt;
    logic [3:0]  s_ovf;
    logic [15:0] s_cpi;

    svc_rv_perf_mon u_dut (
        .clk(clk), .rst(rst), .start(d_start), .stop(d_stop), .clear(d_clear),
        .retire(d_retire), .evt(d_evt), .running(d_running), .cycles(d_cycles),
        .instrs(d_instrs), .evt_cnt(d_evt_cnt), .ovf(d_ovf), .cpi(d_cpi),
        .cpi_div0(d_cpi_div0), .cpi_valid(d_cpi_valid), .cpi_ready(d_ready)
    );

    svc_rv_perf_mon #(.CNT_W(8), .NUM_EVT(2), .FRAC_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s_start), .stop(s_stop), .clear(s_clear),
        .retire(s_retire), .evt(s_evt), .running(s_running), .cycles(s_cycles),
        .instrs(s_instrs), .evt_cnt(s_evt_cnt), .ovf(s_ovf), .cpi(s_cpi),
        .cpi_div0(s_cpi_div0), .cpi_valid(s_cpi_valid), .cpi_ready(s_ready)
    );

    typedef struct {
        logic [39:0] cpi;
        logic        div0;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int lat0, output int lat);
        lat = lat0;
        while (!d_cpi_valid && lat < 200) begin
            step();
            lat++;
        end
    endtask

    function automatic logic [39:0] model_cpi(input longint cyc, input longint ins);
        longint q;
        if (ins == 0) return '1;
        q = (cyc << 8) / ins;
        return q[39:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        n_cmp++; if (d_running !== 1'b0 || d_cpi_valid !== 1'b0) begin n_mis++;
            $display("FAIL reset_flags: running=%b valid=%b want 0/0", d_running, d_cpi_valid); end
        n_cmp++; if ({d_cycles, d_instrs, d_evt_cnt} !== 128'd0) begin n_mis++;
            $display("FAIL reset_counters: got %0h want 0", {d_cycles, d_instrs, d_evt_cnt}); end
        n_cmp++; if ({d_ovf, d_cpi, d_cpi_div0} !== 45'd0) begin n_mis++;
            $display("FAIL reset_ovf_cpi: got %0h want 0", {d_ovf, d_cpi, d_cpi_div0}); end
        n_cmp++; if ({s_cycles, s_ovf, s_running, s_cpi_valid} !== 14'd0) begin n_mis++;
            $display("FAIL reset_narrow: got %0h want 0", {s_cycles, s_ovf, s_running, s_cpi_valid}); end
    endtask

    // 288-cycle window, retire every 2nd cycle; start pulses in DIV and DONE; held DONE.
    task automatic test_cpi_basic();
        int   cyc = 0, ins = 0, ev0 = 0, lat;
        exp_t e;
        logic [39:0] held;
        d_start = 1; step(); d_start = 0;
        for (int i = 0; i < 288; i++) begin
            d_retire = i[0];
            d_evt[0] = (i % 3 == 0);
            d_stop   = (i == 287);
            cyc++; ins += int'(d_retire); ev0 += int'(d_evt[0]);
            if (d_stop) sb_q.push_back('{model_cpi(cyc, ins), 1'b0, 41});
            step();
        end
        d_stop = 0; d_retire = 0; d_evt = '0;
        d_start = 1; step(); d_start = 0;
        wait_valid(2, lat);
        e = sb_q.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_mis++;
            $display("FAIL basic_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (d_cpi !== e.cpi || d_cpi !== 40'h200) begin n_mis++;
            $display("FAIL basic_cpi: got %0h want %0h", d_cpi, e.cpi); end
        n_cmp++; if (d_cpi_div0 !== e.div0) begin n_mis++;
            $display("FAIL basic_div0: got %b want %b", d_cpi_div0, e.div0); end
        n_cmp++; if (d_cycles !== 32'(cyc) || d_instrs !== 32'(ins)) begin n_mis++;
            $display("FAIL basic_counts: got %0d/%0d want %0d/%0d", d_cycles, d_instrs, cyc, ins); end
        n_cmp++; if (d_evt_cnt !== {32'd0, 32'(ev0)}) begin n_mis++;
            $display("FAIL basic_evt: got %0h want %0h", d_evt_cnt, {32'd0, 32'(ev0)}); end
        held = d_cpi;
        for (int i = 0; i < 20; i++) begin
            d_start = (i == 5);
            step();
            n_cmp++; if (d_cpi_valid !== 1'b1 || d_cpi !== held) begin n_mis++;
                $display("FAIL hold_%0d: valid=%b cpi=%0h want 1/%0h", i, d_cpi_valid, d_cpi, held); end
        end
        d_start = 0;
        n_cmp++; if (d_cycles !== 32'(cyc) || d_running !== 1'b0) begin n_mis++;
            $display("FAIL hold_counters: cycles=%0d running=%b want %0d/0", d_cycles, d_running, cyc); end
        d_ready = 1; step(); d_ready = 0;
        n_cmp++; if (d_cpi_valid !== 1'b0 || d_running !== 1'b0) begin n_mis++;
            $display("FAIL accept: valid=%b running=%b want 0/0", d_cpi_valid, d_running); end
        n_cmp++; if (d_cycles !== 32'(cyc) || d_instrs !== 32'(ins)) begin n_mis++;
            $display("FAIL readable_after: got %0d/%0d want %0d/%0d", d_cycles, d_instrs, cyc, ins); end
    endtask

    task automatic test_div0();
        int   lat;
        exp_t e;
        d_start = 1; step(); d_start = 0;
        for (int i = 0; i < 10; i++) begin
            d_stop = (i == 9);
            if (d_stop) sb_q.push_back('{model_cpi(10, 0), 1'b1, 2});
            step();
        end
        d_stop = 0;
        wait_valid(1, lat);
        e = sb_q.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_mis++;
            $display("FAIL div0_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (d_cpi !== e.cpi || d_cpi_div0 !== e.div0) begin n_mis++;
            $display("FAIL div0_result: got %0h/%b want %0h/%b", d_cpi, d_cpi_div0, e.cpi, e.div0); end
        n_cmp++; if (d_cycles !== 32'd10) begin n_mis++;
            $display("FAIL div0_cycles: got %0d want 10", d_cycles); end
        d_ready = 1; step(); d_ready = 0;
    endtask

    // evt[1] pulsed 7 times; stop and start together must enter DIV, not restart.
    task automatic test_stop_start_same();
        int   lat, ins = 0;
        exp_t e;
        d_start = 1; step(); d_start = 0;
        for (int i = 0; i < 12; i++) begin
            d_retire = 1'b1; ins++;
            d_evt[1] = (i % 3 != 0) && (i < 11);
            d_stop   = (i == 11);
            d_start  = (i == 11);
            if (d_stop) sb_q.push_back('{model_cpi(12, ins), 1'b0, 41});
            step();
        end
        d_stop = 0; d_start = 0; d_retire = 0; d_evt = '0;
        n_cmp++; if (d_running !== 1'b0) begin n_mis++;
            $display("FAIL stop_wins: running=%b want 0", d_running); end
        n_cmp++; if (d_evt_cnt[63:32] !== 32'd7) begin n_mis++;
            $display("FAIL evt1_count: got %0d want 7", d_evt_cnt[63:32]); end
        wait_valid(1, lat);
        e = sb_q.pop_front();
        n_cmp++; if (lat !== e.lat || d_cpi !== e.cpi) begin n_mis++;
            $display("FAIL ss_cpi: got lat %0d cpi %0h want %0d/%0h", lat, d_cpi, e.lat, e.cpi); end
        d_ready = 1; step(); d_ready = 0;
    endtask

    task automatic test_clear_mid_div();
        int seen = 0;
        d_start = 1; step(); d_start = 0;
        for (int i = 0; i < 20; i++) begin
            d_retire = 1'b1; d_evt = 2'b11; d_stop = (i == 19);
            step();
        end
        d_stop = 0; d_retire = 0; d_evt = '0;
        repeat (5) step();
        d_clear = 1; step(); d_clear = 0;
        n_cmp++; if (d_running !== 1'b0 || d_cpi_valid !== 1'b0) begin n_mis++;
            $display("FAIL clear_flags: running=%b valid=%b want 0/0", d_running, d_cpi_valid); end
        n_cmp++; if ({d_cycles, d_instrs, d_evt_cnt} !== 128'd0) begin n_mis++;
            $display("FAIL clear_counters: got %0h want 0", {d_cycles, d_instrs, d_evt_cnt}); end
        n_cmp++; if ({d_ovf, d_cpi, d_cpi_div0} !== 45'd0) begin n_mis++;
            $display("FAIL clear_cpi: got %0h want 0", {d_ovf, d_cpi, d_cpi_div0}); end
        for (int i = 0; i < 60; i++) begin
            step();
            seen += int'(d_cpi_valid);
        end
        n_cmp++; if (seen !== 0) begin n_mis++;
            $display("FAIL clear_no_valid: valid seen %0d cycles want 0", seen); end
    endtask

    // CNT_W=8, 300-cycle window: cycles wraps (or saturates) and ovf[0] sticks.
    task automatic test_overflow();
        int          m_cyc = 0, lat = 1;
        logic [3:0]  m_ovf = '0;
        logic [15:0] m_cpi;
        longint      q;
        s_start = 1; step(); s_start = 0;
        for (int i = 0; i < 300; i++) begin
            s_retire = (i < 100);
            s_stop   = (i == 299);
            if (m_cyc == 255) begin
                m_ovf[0] = 1'b1;
`ifdef SVC_RV_PERF_MON_SAT_EN
                m_cyc = 255;
`else
                m_cyc = 0;
`endif
            end else begin
                m_cyc++;
            end
            step();
        end
        s_stop = 0; s_retire = 0;
        q = (longint'(m_cyc) << 8) / 100;
        m_cpi = q[15:0];
        n_cmp++; if (s_cycles !== 8'(m_cyc)) begin n_mis++;
            $display("FAIL ovf_cycles: got %0d want %0d", s_cycles, m_cyc); end
        n_cmp++; if (s_ovf !== m_ovf || s_instrs !== 8'd100) begin n_mis++;
            $display("FAIL ovf_bits: ovf=%b instrs=%0d want %b/100", s_ovf, s_instrs, m_ovf); end
        while (!s_cpi_valid && lat < 100) begin
            step();
            lat++;
        end
        n_cmp++; if (lat !== 17 || s_cpi !== m_cpi || s_cpi_div0 !== 1'b0) begin n_mis++;
            $display("FAIL ovf_cpi: lat %0d cpi %0h div0 %b want 17/%0h/0", lat, s_cpi, s_cpi_div0, m_cpi); end
        s_ready = 1; step(); s_ready = 0;
        n_cmp++; if (s_cpi_valid !== 1'b0 || s_ovf !== m_ovf) begin n_mis++;
            $display("FAIL ovf_sticky: valid=%b ovf=%b want 0/%b", s_cpi_valid, s_ovf, m_ovf); end
    endtask

    initial begin
        test_reset();
        test_cpi_basic();
        test_div0();
        test_stop_start_same();
        test_clear_mid_div();
        test_overflow();
        n_cmp++; if (sb_q.size() !== 0) begin n_mis++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
